// File: rtl/zoom_in_replicacao_if.sv
// Memory-side bus of the zoom-in engine: source read port plus destination write port.
// Latency: read data is expected one clock after rd_en; writes take effect on the wr_en cycle.
// Backpressure: none; the engine assumes both memories accept one access per cycle.
//
// master: engine side (drives read strobe/address and the whole write port)
// slave : memory side (returns rd_data)
interface zoom_in_replicacao_if #(
  parameter int PIXEL_W     = 8,
  parameter int ADDR_ORIG_W = 15,
  parameter int ADDR_DEST_W = 19
);
  logic                   rd_en;
  logic [ADDR_ORIG_W-1:0] rd_addr;
  logic [PIXEL_W-1:0]     rd_data;
  logic                   wr_en;
  logic [ADDR_DEST_W-1:0] wr_addr;
  logic [PIXEL_W-1:0]     wr_data;
  logic [9:0]             x_dest;
  logic [9:0]             y_dest;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data, x_dest, y_dest
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data, x_dest, y_dest
  );
endinterface

// File: rtl/zoom_in_replicacao.sv
// Zoom-in by pixel replication: each source pixel is read once and written to an NxN block (N=2/4).
// Latency: per source pixel 1 read + 1 wait + N*N write cycles; concluido at 1 + P*(2+N*N) after start.
// Backpressure: none; memories must accept one access per cycle, iniciar is ignored while busy.
//
// Ports: clk, reset_n (async active-low); iniciar/fator_zoom start a run (01=2x, 10=4x, others
// raise erro); ocupado/concluido report run status; mem carries the source read and
// destination write ports (see zoom_in_replicacao_if).
module zoom_in_replicacao #(
  parameter int LARG_ORIG   = 160,
  parameter int ALT_ORIG    = 120,
  parameter int PIXEL_W     = 8,
  parameter int ADDR_ORIG_W = 15,
  parameter int ADDR_DEST_W = 19
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic [1:0]            fator_zoom,
  output logic                  ocupado,
  output logic                  concluido,
  output logic                  erro,
  zoom_in_replicacao_if.master  mem
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LER     = 3'd1;
  localparam logic [2:0] ESPERA  = 3'd2;
  localparam logic [2:0] ESCREVE = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  localparam logic [9:0] XS_LAST = 10'(LARG_ORIG - 1);
  localparam logic [9:0] YS_LAST = 10'(ALT_ORIG - 1);

  logic [2:0]         state;
  logic               zoom4;   // 1: N=4, 0: N=2
  logic [9:0]         xs;
  logic [9:0]         ys;
  logic [1:0]         dx;
  logic [1:0]         dy;
  logic [PIXEL_W-1:0] pixel;
  logic [1:0]         n_last;  // N-1

  assign n_last = zoom4 ? 2'd3 : 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= OCIOSO;
      zoom4 <= 1'b0;
      xs    <= '0;
      ys    <= '0;
      dx    <= '0;
      dy    <= '0;
      pixel <= '0;
      erro  <= 1'b0;
    end else begin
      erro <= 1'b0;
      case (state)
        OCIOSO: begin
          if (iniciar) begin
            if (fator_zoom == 2'b01 || fator_zoom == 2'b10) begin
              zoom4 <= (fator_zoom == 2'b10);
              xs    <= '0;
              ys    <= '0;
              dx    <= '0;
              dy    <= '0;
              state <= LER;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        LER: state <= ESPERA;
        ESPERA: begin
          pixel <= mem.rd_data;
          state <= ESCREVE;
        end
        ESCREVE: begin
          // Row-major walk of the NxN block, then step to the next source pixel.
          if (dx != n_last) begin
            dx <= dx + 2'd1;
          end else begin
            dx <= '0;
            if (dy != n_last) begin
              dy <= dy + 2'd1;
            end else begin
              dy <= '0;
              if (xs == XS_LAST) begin
                xs <= '0;
                if (ys == YS_LAST) begin
                  state <= FIM;
                end else begin
                  ys    <= ys + 10'd1;
                  state <= LER;
                end
              end else begin
                xs    <= xs + 10'd1;
                state <= LER;
              end
            end
          end
        end
        FIM:     state <= OCIOSO;
        default: state <= OCIOSO;
      endcase
    end
  end

  // Status and strobes decode straight from the state, so an async reset clears them at once.
  assign ocupado   = (state == LER) || (state == ESPERA) || (state == ESCREVE);
  assign concluido = (state == FIM);
  assign mem.rd_en = (state == LER);
  assign mem.wr_en = (state == ESCREVE);

  // N is a power of two, so the block origin is a shift of the source coordinate.
  assign mem.x_dest = zoom4 ? ((xs << 2) + {8'd0, dx}) : ((xs << 1) + {9'd0, dx[0]});
  assign mem.y_dest = zoom4 ? ((ys << 2) + {8'd0, dy}) : ((ys << 1) + {9'd0, dy[0]});

  logic [ADDR_DEST_W-1:0] larg_dest;
  assign larg_dest = zoom4 ? ADDR_DEST_W'(LARG_ORIG * 4) : ADDR_DEST_W'(LARG_ORIG * 2);

  // Constant-coefficient products; the declared widths hold the largest addresses exactly.
  assign mem.wr_addr = ADDR_DEST_W'(mem.y_dest) * larg_dest + ADDR_DEST_W'(mem.x_dest);
  assign mem.rd_addr = ADDR_ORIG_W'(ys) * ADDR_ORIG_W'(LARG_ORIG) + ADDR_ORIG_W'(xs);
  assign mem.wr_data = pixel;

endmodule

// File: doc/zoom_in_replicacao.md
Name: zoom_in_replicacao

Overview:
Sequential zoom-in engine and the counterpart of the block-average zoom-out path. It reads every pixel of a source image from a read port once. It then writes that pixel to an N×N block (N = 2 or 4) of a destination frame buffer through a write port. The block sits between the source image RAM and the output frame buffer and is started by the control FSM.

Parameters:
LARG_ORIG, 160, source image width in pixels (fixed for the run)
ALT_ORIG, 120, source image height in pixels
PIXEL_W, 8, pixel data width in bits
ADDR_ORIG_W, 15, source linear address width (must hold LARG_ORIG*ALT_ORIG-1)
ADDR_DEST_W, 19, destination linear address width (must hold 16*LARG_ORIG*ALT_ORIG-1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
iniciar  in  1  start pulse, sampled only in OCIOSO
fator_zoom  in  2  01 = 2x, 10 = 4x; captured when the start is accepted
ocupado  out  1  high while a run is in progress
concluido  out  1  one-cycle pulse when the run is complete
erro  out  1  one-cycle pulse when iniciar arrives with an invalid fator_zoom
rd_en  out  1  source read strobe
rd_addr  out  ADDR_ORIG_W  source address = ys*LARG_ORIG + xs
rd_data  in  PIXEL_W  source data, valid exactly 1 cycle after rd_en
wr_en  out  1  destination write strobe
wr_addr  out  ADDR_DEST_W  destination linear address
wr_data  out  PIXEL_W  destination pixel
x_dest  out  10  destination X of the current write
y_dest  out  10  destination Y of the current write

Behaviour:
- Reset (async, reset_n=0):
  - state = OCIOSO.
  - All outputs 0; all counters (xs, ys, dx, dy) 0; pixel register 0.
  - Reset mid-run aborts immediately; no further rd_en or wr_en until a new iniciar.
- States: OCIOSO, LER, ESPERA, ESCREVE, FIM.
- OCIOSO:
  - iniciar=1 with fator_zoom in {01,10}: latch N, clear xs/ys/dx/dy, go to LER.
  - iniciar=1 with fator 00 or 11: erro=1 on the next cycle for 1 cycle, stay in OCIOSO, no memory access.
- LER (1 cycle): rd_en=1, rd_addr = ys*LARG_ORIG + xs.
- ESPERA (1 cycle): rd_data is valid this cycle and is captured into the pixel register at the end of the cycle.
- ESCREVE (N*N cycles):
  - wr_en=1 every cycle, wr_data = pixel register.
  - Sub-block order is row-major: dy outer, dx inner, both 0..N-1.
  - x_dest = xs*N + dx; y_dest = ys*N + dy; wr_addr = y_dest*(LARG_ORIG*N) + x_dest.
  - Exact arithmetic, no truncation within the declared widths.
  - On the last sub-pixel (dx=dy=N-1):
    - If xs=LARG_ORIG-1 and ys=ALT_ORIG-1, go to FIM.
    - Otherwise advance xs (xs wraps to 0 and ys increments at xs=LARG_ORIG-1), clear dx/dy, go to LER.
- FIM (1 cycle): concluido=1, then OCIOSO.
- ocupado = 1 in LER, ESPERA and ESCREVE; 0 in OCIOSO and FIM.
- rd_en, wr_en, concluido and erro are 0 outside the states listed above. wr_addr, x_dest and y_dest are don't-care when wr_en=0; rd_addr is don't-care when rd_en=0.
- Timing: with iniciar accepted at cycle 0 and P = LARG_ORIG*ALT_ORIG, concluido is high at cycle 1 + P*(2 + N*N).
- iniciar while ocupado=1 or in FIM is ignored. fator_zoom changes mid-run have no effect.
- Each destination address is written exactly once per run; the total write count is P*N*N.
- Address generation may use incremental counters instead of multipliers, but the results must equal the formulas above.

Test Plan:
(Parameters LARG_ORIG=4, ALT_ORIG=3, PIXEL_W=8; source RAM holds src[i]=i+10.)
- 2x run, iniciar at cycle 0:
  - rd_en at cycle 1 with rd_addr=0.
  - Writes at cycles 3..6 to addresses 0,1,8,9 with data 10.
  - Second read at cycle 7 with rd_addr=1.
  - Last write to address 47 with data 21; concluido at cycle 73; ocupado low from cycle 73.
- 4x run:
  - First 16 writes go to addresses 0,1,2,3,16,17,18,19,32..35,48..51 with data 10.
  - concluido at cycle 217; 192 writes in total, each destination address 0..191 hit exactly once.
- fator_zoom=00 with iniciar:
  - erro=1 for 1 cycle on the next cycle.
  - rd_en and wr_en stay 0; ocupado stays 0.
- iniciar pulsed again, and fator_zoom flipped to 10, during a 2x run: no restart, timing and addresses identical to the 2x scenario.
- reset_n low during ESCREVE of the 5th source pixel:
  - All outputs 0 asynchronously, no writes afterwards.
  - A subsequent 2x run completes normally with concluido at cycle 73 relative to its iniciar.
- Back-to-back runs: iniciar the cycle after concluido is accepted and the second run matches the first exactly.
